imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, pipelined immediate/data extender for the MIPS datapath. It replaces the fixed 16-to-32 sign extension with a mode-selected extender covering sign, zero, upper-immediate (LUI) and byte/halfword load extension. The result is registered behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between decode and execute, or between memory and writeback, without combinational ready paths.

## Interface
Parameters:
- IN_WIDTH, 16, width of `in_data`; must satisfy 16 <= IN_WIDTH <= OUT_WIDTH.
- OUT_WIDTH, 32, width of `out_data`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_WIDTH  immediate field or load data.
- in_mode  in  3  extension mode (encodings under Operation).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  OUT_WIDTH  extended result.
- out_err  out  1  the beat used an illegal mode.

## Operation
- A beat transfers on the input when `in_valid && in_ready` at a rising edge. It transfers on the output when `out_valid && out_ready`.
- Mode encodings, with d = `in_data`:
  - 0 SIGN: replicate d[IN_WIDTH-1] into the upper OUT_WIDTH-IN_WIDTH bits.
  - 1 ZERO: upper bits are 0.
  - 2 UPPER: `out_data` = d shifted left by OUT_WIDTH-IN_WIDTH; the low bits are 0. When IN_WIDTH == OUT_WIDTH, the output equals d.
  - 3 BYTE_S: sign-extend d[7:0] to OUT_WIDTH.
  - 4 BYTE_U: zero-extend d[7:0].
  - 5 HALF_S: sign-extend d[15:0].
  - 6, 7: illegal. `out_data` = 0 and `out_err` = 1. The beat still flows and is not dropped.
- Extension is computed when the beat is accepted. The stored result is what is presented; it does not depend on `in_mode` after acceptance.
- Storage is a main register, which drives the outputs, plus one skid register.
- States:
  - EMPTY: both registers empty.
  - ONE: main register full.
  - FULL: main and skid registers full.
- Transitions, with acc = input transfer and pop = output transfer:
  - EMPTY, acc → ONE.
  - ONE, acc & !pop → FULL; the new beat goes to skid.
  - ONE, acc & pop → ONE; the new beat goes to main.
  - ONE, !acc & pop → EMPTY.
  - FULL, pop → ONE; skid moves to main.
  - FULL, no acc is possible.
- `in_ready` = (state != FULL), decoded from registered state only. `out_valid` = (state != EMPTY).
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush or reset.
- Flush:
  - Next state is EMPTY, regardless of acc or pop in the same cycle.
  - A beat presented with flush is discarded, even if `in_ready` = 1.
  - Flush takes priority over every other event.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on `out_data` after edge N.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- Reset asserted, at any time including mid-transfer:
  - state = EMPTY, `out_valid` = 0, `out_data` = 0, `out_err` = 0, `in_ready` = 1.
  - Held beats are lost.
- On reset release, the first acceptance can occur at the first rising edge with `rst_n` = 1.
- When `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_err` hold stable until the pop.
- With `out_ready` low, the block stalls upstream after 2 accepted beats. `in_ready` falls the cycle after the second acceptance.
- Registers of empty entries hold stale values. They are not cleared except by reset.

## Structure
- Package `mips_ext_pkg` holds:
  - the mode constants EXT_SIGN … EXT_HALF_S (3-bit);
  - the state encoding ST_EMPTY/ST_ONE/ST_FULL.
- Sub-module `imm_ext_core` is purely combinational: (`in_data`, `in_mode`) → (ext, err), parametrised by IN_WIDTH/OUT_WIDTH. The skid and control logic live in `imm_ext_pipe`.

## Test plan
- Reset, then one beat each of SIGN 0x8001, ZERO 0x8001 and UPPER 0x1234, with `out_ready` = 1. Required outputs are 0xFFFF8001, 0x00008001 and 0x12340000, each one cycle after acceptance, with `out_err` = 0.
- BYTE_S 0x0080 → 0xFFFFFF80. BYTE_U 0xFF80 → 0x00000080. HALF_S 0x7FFF → 0x00007FFF. Mode 6 with 0xFFFF → `out_data` 0, `out_err` 1.
- Stream 5 SIGN beats 1..5 with `out_ready` = 0 for 4 cycles, then 1. Required:
  - `in_ready` drops after the 2nd acceptance;
  - `out_data` holds 1 while stalled;
  - outputs then arrive in order 1..5, with no loss or duplication.
- In FULL, assert flush together with `in_valid` = 1 and `out_ready` = 1. Next cycle requires `out_valid` = 0, `in_ready` = 1, and the flushed input never appears.
- Drop `rst_n` asynchronously mid-stream while FULL. Required immediately, before the next edge: `out_valid` = 0, `out_data` = 0, `in_ready` = 1. After release, a SIGN 0xFFFE beat yields 0xFFFFFFFE.
- Re-instantiate with IN_WIDTH = OUT_WIDTH = 32:
  - SIGN 0x80000000 → 0x80000000;
  - UPPER 0x00000001 → 0x00000001;
  - random valid/ready toggling over 1000 beats matches a reference-model scoreboard.

Source files
------------

// File: rtl/mips_ext_pkg.sv
// Shared mode encodings and skid-buffer state encoding for the immediate/data extender.
package mips_ext_pkg;

    localparam logic [2:0] EXT_SIGN   = 3'd0;
    localparam logic [2:0] EXT_ZERO   = 3'd1;
    localparam logic [2:0] EXT_UPPER  = 3'd2;
    localparam logic [2:0] EXT_BYTE_S = 3'd3;
    localparam logic [2:0] EXT_BYTE_U = 3'd4;
    localparam logic [2:0] EXT_HALF_S = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } ext_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: maps (in_data, in_mode) to the OUT_WIDTH result plus an illegal-mode flag.
module imm_ext_core
    import mips_ext_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [2:0]           in_mode,
    output logic [OUT_WIDTH-1:0] ext,
    output logic                 err
);

    localparam int SHIFT = OUT_WIDTH - IN_WIDTH;

    logic signed [IN_WIDTH-1:0] data_s;
    logic signed [7:0]          byte_s;
    logic signed [15:0]         half_s;

    assign data_s = in_data;
    assign byte_s = in_data[7:0];
    assign half_s = in_data[15:0];

    // Size casts of signed operands sign-extend, and stay legal when SHIFT is 0.
    always_comb begin
        ext = '0;
        err = 1'b0;
        case (in_mode)
            EXT_SIGN:   ext = OUT_WIDTH'(data_s);
            EXT_ZERO:   ext = OUT_WIDTH'(in_data);
            EXT_UPPER:  ext = OUT_WIDTH'(in_data) << SHIFT;
            EXT_BYTE_S: ext = OUT_WIDTH'(byte_s);
            EXT_BYTE_U: ext = OUT_WIDTH'(in_data[7:0]);
            EXT_HALF_S: ext = OUT_WIDTH'(half_s);
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered mode-selected extender behind a valid/ready handshake with a 2-entry skid buffer.
module imm_ext_pipe
    import mips_ext_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [2:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_err
);

    ext_state_e           state_q, state_d;
    logic [OUT_WIDTH-1:0] main_data_q, main_data_d;
    logic                 main_err_q, main_err_d;
    logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                 skid_err_q, skid_err_d;

    logic [OUT_WIDTH-1:0] ext;
    logic                 ext_err;
    logic                 acc;
    logic                 pop;

    imm_ext_core #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_core (
        .in_data(in_data),
        .in_mode(in_mode),
        .ext    (ext),
        .err    (ext_err)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    // Flush suppresses both handshakes so no data register moves on that edge.
    assign acc = in_valid && in_ready && !flush;
    assign pop = out_valid && out_ready && !flush;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_data_d = ext;
                    main_err_d  = ext_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && !pop) begin
                    skid_data_d = ext;
                    skid_err_d  = ext_err;
                    state_d     = ST_FULL;
                end else if (acc && pop) begin
                    main_data_d = ext;
                    main_err_d  = ext_err;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: 16->32 instance with directed vectors, 32->32 instance with random traffic.
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    logic        flush32 = 1'b0;
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] in_data32 = '0;
    logic [2:0]  in_mode32 = '0;
    logic        out_valid32;
    logic        out_ready32 = 1'b0;
    logic [31:0] out_data32;
    logic        out_err32;

    exp_t        q16[$];
    exp_t        q32[$];
    logic [31:0] exp_d16, exp_d32;
    logic        exp_e16, exp_e32;
    logic        acc16_s, acc32_s;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    imm_ext_pipe #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_mode(in_mode32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32), .out_err(out_err32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void ref_ext(input logic [31:0] d, input logic [2:0] m, input int in_w,
                                    output logic [31:0] r, output logic e);
        logic [63:0] mask, wide;
        mask = (64'd1 << in_w) - 64'd1;
        wide = {32'd0, d} & mask;
        e = 1'b0;
        case (m)
            3'd0: r = wide[in_w-1] ? 32'(wide | ~mask) : 32'(wide);
            3'd1: r = 32'(wide);
            3'd2: r = 32'(wide << (32 - in_w));
            3'd3: r = {{24{d[7]}}, d[7:0]};
            3'd4: r = {24'h0, d[7:0]};
            3'd5: r = {{16{d[15]}}, d[15:0]};
            default: begin
                r = 32'd0;
                e = 1'b1;
            end
        endcase
    endfunction

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon16_unexpected: got %h, expected no beat", out_data);
            end else begin
                e = q16.pop_front();
                check("mon16_data", out_data, e.d);
                check("mon16_err", 32'(out_err), 32'(e.e));
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n && out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon32_unexpected: got %h, expected no beat", out_data32);
            end else begin
                e = q32.pop_front();
                check("mon32_data", out_data32, e.d);
                check("mon32_err", 32'(out_err32), 32'(e.e));
            end
        end
    end

    task automatic step16();
        @(negedge clk);
        acc16_s = in_valid && in_ready && !flush && rst_n;
        @(posedge clk);
        if (acc16_s) q16.push_back({exp_d16, exp_e16});
        #1;
    endtask

    task automatic step32();
        @(negedge clk);
        acc32_s = in_valid32 && in_ready32 && !flush32 && rst_n;
        @(posedge clk);
        if (acc32_s) q32.push_back({exp_d32, exp_e32});
        #1;
    endtask

    task automatic send16(input logic [2:0] m, input logic [15:0] d, input logic [31:0] xd, input logic xe);
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = d;
        exp_d16   = xd;
        exp_e16   = xe;
        out_ready = 1'b1;
        step16();
        check("latency_valid16", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step16();
    endtask

    task automatic send32(input logic [2:0] m, input logic [31:0] d, input logic [31:0] xd, input logic xe);
        in_valid32  = 1'b1;
        in_mode32   = m;
        in_data32   = d;
        exp_d32     = xd;
        exp_e32     = xe;
        out_ready32 = 1'b1;
        step32();
        check("latency_valid32", 32'(out_valid32), 32'd1);
        in_valid32 = 1'b0;
        step32();
    endtask

    task automatic drain16();
        int b = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q16.size() != 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("drain16_left", 32'(q16.size()), 32'd0);
    endtask

    task automatic drain32();
        int b = 0;
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        while (q32.size() != 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("drain32_left", 32'(q32.size()), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int sent;
        logic [31:0] rd;
        logic        re;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed extension vectors.
        send16(3'd0, 16'h8001, 32'hFFFF8001, 1'b0);
        send16(3'd1, 16'h8001, 32'h00008001, 1'b0);
        send16(3'd2, 16'h1234, 32'h12340000, 1'b0);
        send16(3'd3, 16'h0080, 32'hFFFFFF80, 1'b0);
        send16(3'd4, 16'hFF80, 32'h00000080, 1'b0);
        send16(3'd5, 16'h7FFF, 32'h00007FFF, 1'b0);
        send16(3'd6, 16'hFFFF, 32'h00000000, 1'b1);
        send16(3'd7, 16'h1234, 32'h00000000, 1'b1);
        send16(3'd0, 16'h7FFF, 32'h00007FFF, 1'b0);
        drain16();

        // Stall: five SIGN beats with out_ready low for the first four cycles.
        in_valid = 1'b1;
        in_mode  = 3'd0;
        exp_e16  = 1'b0;
        n   = 1;
        cyc = 0;
        while (n <= 5 && cyc < 50) begin
            in_data   = 16'(n);
            exp_d16   = 32'(n);
            out_ready = (cyc >= 4);
            step16();
            if (acc16_s) begin
                if (n == 2) check("stall_in_ready", 32'(in_ready), 32'd0);
                n++;
            end
            if (!out_ready) check("stall_hold", out_data, 32'd1);
            cyc++;
        end
        check("stall_sent", 32'(n), 32'd6);
        drain16();

        // Flush while FULL, with a new beat and a pop offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 3'd1;
        in_data   = 16'h1111;
        exp_d16   = 32'h00001111;
        exp_e16   = 1'b0;
        step16();
        in_data = 16'h2222;
        exp_d16 = 32'h00002222;
        step16();
        check("full_in_ready", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        in_data   = 16'h3333;
        exp_d16   = 32'h00003333;
        out_ready = 1'b1;
        step16();
        flush    = 1'b0;
        in_valid = 1'b0;
        q16.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        send16(3'd0, 16'h0005, 32'h00000005, 1'b0);
        drain16();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 3'd0;
        in_data   = 16'h0011;
        exp_d16   = 32'h00000011;
        exp_e16   = 1'b0;
        step16();
        in_data = 16'h0012;
        exp_d16 = 32'h00000012;
        step16();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_err", 32'(out_err), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        q16.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send16(3'd0, 16'hFFFE, 32'hFFFFFFFE, 1'b0);
        drain16();

        // Full-width instance: directed then random handshake traffic.
        send32(3'd0, 32'h80000000, 32'h80000000, 1'b0);
        send32(3'd2, 32'h00000001, 32'h00000001, 1'b0);
        send32(3'd3, 32'h123456F0, 32'hFFFFFFF0, 1'b0);
        drain32();

        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid32  = 1'($urandom_range(0, 1));
            in_data32   = $urandom();
            in_mode32   = 3'($urandom_range(0, 7));
            out_ready32 = ($urandom_range(0, 3) != 0);
            ref_ext(in_data32, in_mode32, 32, rd, re);
            exp_d32 = rd;
            exp_e32 = re;
            step32();
            if (acc32_s) sent++;
            cyc++;
        end
        check("rand32_sent", 32'(sent), 32'd1000);
        drain32();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
